// File: rtl/router_fsm.sv
// Control FSM for the 1x3 packet router: header decode, load sequencing and FIFO-full stalls.
// Optional build macro ROUTER_FSM_STATUS_EN exposes the raw state code and a completed-packet counter.
//
// state | meaning
// DA    | decode address of incoming header
// WTE   | wait until destination FIFO is empty
// LFD   | load header byte
// LD    | load payload bytes
// FFS   | destination FIFO full, hold
// LAF   | load the byte held during full
// LP    | load parity byte
// CPE   | check parity error
module router_fsm #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
`ifdef ROUTER_FSM_STATUS_EN
  ,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] pkt_cnt
`endif
);

  typedef enum logic [2:0] {
    S_DA  = 3'd0,
    S_WTE = 3'd1,
    S_LFD = 3'd2,
    S_LD  = 3'd3,
    S_FFS = 3'd4,
    S_LAF = 3'd5,
    S_LP  = 3'd6,
    S_CPE = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       soft_reset_sel;
  logic       empty_sel;
  logic       empty_hdr;
  logic       hdr_valid;

  assign hdr_valid = pkt_valid && (data_in != 2'b11);

  // empty_hdr follows the incoming header; the *_sel signals follow the latched address
  always_comb begin
    soft_reset_sel = 1'b0;
    empty_sel      = 1'b0;
    empty_hdr      = 1'b0;
    case (addr_q)
      2'd0:    begin soft_reset_sel = soft_reset_0; empty_sel = empty_0; end
      2'd1:    begin soft_reset_sel = soft_reset_1; empty_sel = empty_1; end
      2'd2:    begin soft_reset_sel = soft_reset_2; empty_sel = empty_2; end
      default: begin soft_reset_sel = 1'b0;         empty_sel = 1'b0;    end
    endcase
    case (data_in)
      2'd0:    empty_hdr = empty_0;
      2'd1:    empty_hdr = empty_1;
      2'd2:    empty_hdr = empty_2;
      default: empty_hdr = 1'b0;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if ((state_q == S_DA) && hdr_valid) addr_d = data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_DA;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q != S_DA) && soft_reset_sel) begin
      state_d = S_DA;
    end else begin
      case (state_q)
        S_DA:    if (hdr_valid) state_d = empty_hdr ? S_LFD : S_WTE;
        S_WTE:   if (empty_sel) state_d = S_LFD;
        S_LFD:   state_d = S_LD;
        S_LD: begin
          if (fifo_full)       state_d = S_FFS;
          else if (!pkt_valid) state_d = S_LP;
        end
        S_FFS:   if (!fifo_full) state_d = S_LAF;
        S_LAF: begin
          if (parity_done)        state_d = S_DA;
          else if (low_pkt_valid) state_d = S_LP;
          else                    state_d = S_LD;
        end
        S_LP:    state_d = S_CPE;
        S_CPE:   state_d = fifo_full ? S_FFS : S_DA;
        default: state_d = S_DA;
      endcase
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (state_q)
      S_DA:  detect_add = 1'b1;
      S_WTE: busy = 1'b1;
      S_LFD: begin lfd_state = 1'b1; busy = 1'b1; end
      S_LD:  begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      S_FFS: begin full_state = 1'b1; busy = 1'b1; end
      S_LAF: begin laf_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
      S_LP:  begin write_enb_reg = 1'b1; busy = 1'b1; end
      S_CPE: begin rst_int_reg = 1'b1; busy = 1'b1; end
      default: detect_add = 1'b1;
    endcase
  end

`ifdef ROUTER_FSM_STATUS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // only a normal CPE->DA exit counts; soft-reset exits are excluded
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_CPE) && (state_d == S_DA) && !soft_reset_sel) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign state_out = state_q;
  assign pkt_cnt   = cnt_q;
`endif

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Control FSM for the 1x3 packet router. It decodes the 2-bit destination address in the packet header and sequences the header, payload and parity loads into the register block. It handles stalls when the destination FIFO is busy or full. It drives `detect_add` and `write_enb_reg` into the synchronizer, and consumes that block's `fifo_full`, `soft_reset_*` and the FIFO `empty_*` flags.

Parameters:
CNT_W, 8, width of the completed-packet counter (used only when ROUTER_FSM_STATUS_EN is defined)

Ports:
clk  input  1  system clock, all state changes on posedge
rst  input  1  asynchronous, active-low reset
pkt_valid  input  1  high while the source drives header/payload bytes
data_in  input  2  destination address bits [1:0] of the header byte; 0/1/2 valid, 3 invalid
fifo_full  input  1  full flag of the currently selected FIFO, from the synchronizer
empty_0, empty_1, empty_2  input  1 each  FIFO empty flags
soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  per-FIFO read-timeout reset, from the synchronizer
parity_done  input  1  register block has stored the parity byte
low_pkt_valid  input  1  register block saw pkt_valid fall while the FIFO was full
detect_add  output  1  header-decode phase
lfd_state  output  1  load header byte
ld_state  output  1  load payload byte
laf_state  output  1  load the byte held during full
full_state  output  1  FIFO-full stall
write_enb_reg  output  1  write enable toward the FIFOs
rst_int_reg  output  1  clears the internal parity register
busy  output  1  source must hold its current byte

Behaviour:
- States: DA (decode address), WTE (wait till empty), LFD, LD, FFS, LAF, LP (load parity), CPE (check parity error).
- Encoding is implementer's choice. Next state is registered; outputs are Moore, decoded from the state register only.
- rst low: state forced to DA immediately (async). addr_q clears to 0.
- Output values during reset: detect_add=1; all other outputs 0.
- addr_q (2 bits): captured from data_in on every clock in DA when pkt_valid=1 and data_in!=3.
- Destination select: soft_reset_sel and empty_sel are the soft_reset_*/empty_* bits indexed by addr_q.
- DA:
  - pkt_valid=1, data_in<3, empty of data_in's FIFO=1 -> LFD
  - pkt_valid=1, data_in<3, that FIFO not empty -> WTE
  - data_in=3 or pkt_valid=0 -> stay in DA; the invalid header is dropped and busy stays 0.
- WTE: empty_sel=1 -> LFD; else stay.
- LFD -> LD, unconditionally.
- LD, in priority order:
  - fifo_full=1 -> FFS
  - pkt_valid=0 -> LP
  - otherwise stay
- FFS: fifo_full=0 -> LAF; else stay.
- LAF, in priority order:
  - parity_done=1 -> DA
  - low_pkt_valid=1 -> LP
  - otherwise -> LD
- LP -> CPE, unconditionally.
- CPE: fifo_full=1 -> FFS; else DA.
- Soft reset: in any state except DA, soft_reset_sel=1 forces next state DA. It has priority over all other transitions except rst.
- Output decode:
  - detect_add = DA
  - lfd_state = LFD
  - ld_state = LD
  - laf_state = LAF
  - full_state = FFS
  - write_enb_reg = LD | LP | LAF
  - rst_int_reg = CPE
  - busy = LFD | WTE | FFS | LAF | LP | CPE
- Latency: header accepted in DA is written in LFD one cycle later. With no stalls, a packet returns to DA two cycles after pkt_valid falls (LP, CPE).
- Simultaneous events:
  - fifo_full and pkt_valid=0 in LD: FFS wins.
  - soft_reset for a port other than addr_q is ignored.

Optional Feature:
ROUTER_FSM_STATUS_EN
- Defined: adds two outputs.
  - state_out [2:0]: raw state code.
  - pkt_cnt [CNT_W-1:0]: wrapping count of CPE->DA transitions. Reset 0; wraps from all-ones to 0. Not incremented on soft-reset exits.
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
1. rst low mid-packet (state LD) -> within the same cycle detect_add=1, ld_state=0, busy=0; after rst high, FSM stays in DA until pkt_valid.
2. pkt_valid=1, data_in=2'b01, empty_1=1, then 3 payload cycles, then pkt_valid=0 -> state sequence DA, LFD, LD, LD, LD, LP, CPE, DA; write_enb_reg=1 for 4 cycles.
3. data_in=2'b00, empty_0=0 for 5 cycles, then empty_0=1 -> busy=1 for the 5 WTE cycles, then lfd_state=1.
4. In LD, assert fifo_full for 3 cycles -> full_state=1 for 3 cycles, then laf_state=1. With low_pkt_valid=1 the next state is LP; with low_pkt_valid=0 it is LD.
5. In WTE with addr_q=2, assert soft_reset_2 -> next cycle detect_add=1. soft_reset_0 in the same situation has no effect.
6. data_in=2'b11 with pkt_valid=1 -> FSM stays in DA and busy=0. With ROUTER_FSM_STATUS_EN: pkt_cnt increments by 1 per completed packet and wraps at 255->0.
